mii_rx_frame_receiver: RTL and testbench
========================================

Name: mii_rx_frame_receiver

Overview:
Parametrised MII receive front end for the switch port; it is the successor to the fixed-format receive path in `transceiver`. It oversamples the MII RX pins in the system clock domain and detects preamble/SFD at nibble level. It assembles bytes in a selectable nibble order and streams frame bytes with SOF/EOF markers. At EOF it reports CRC-32, length, RX_ER and dribble-nibble status and maintains good/bad frame counters.

Parameters:
SYNC_STAGES, 2, synchroniser depth on all MII RX inputs (min 2)
NIBBLE_ORDER, 0, 0 = low nibble first (IEEE 802.3), 1 = high nibble first
MIN_PREAMBLE_NIBBLES, 4, minimum count of 0x5 nibbles before SFD nibble 0xD
MIN_FRAME_BYTES, 64, shortest legal frame, DA through FCS inclusive
MAX_FRAME_BYTES, 1522, longest legal frame
CRC_CHECK, 1, 1 = check FCS; 0 = crc flag forced 0
COUNTER_WIDTH, 16, width of statistics counters

Ports:
clock  in  1  system clock, at least 4x mii_rx_clock frequency
reset  in  1  asynchronous active-low reset
mii_rx_clock  in  1  MII RX clock, sampled as data
mii_rx_data_valid  in  1  MII RX_DV
mii_rx_error  in  1  MII RX_ER
mii_rx_data  in  4  MII RXD
out_valid  out  1  one-cycle strobe, byte on out_data
out_data  out  8  frame byte
out_sof  out  1  with out_valid: first byte after SFD
out_eof  out  1  with out_valid: last byte of frame
out_error_flags  out  5  valid with out_eof: [0] crc, [1] rx_er, [2] short, [3] long, [4] dribble
frame_length  out  16  bytes after SFD including FCS, valid with out_eof, saturates at 0xFFFF
frames_ok  out  COUNTER_WIDTH  frames with flags==0, wraps
frames_bad  out  COUNTER_WIDTH  frames with any flag set, wraps

Behaviour:
- Reset (reset low, async): all outputs 0, state IDLE, CRC register 0xFFFFFFFF, counters 0.
- Input sampling:
  - mii_rx_clock, dv, er and data each pass through SYNC_STAGES flops.
  - A "tick" is a synchronised 0->1 transition of mii_rx_clock.
  - dv/er/data are sampled only on ticks.
- States and transitions:
  - IDLE: on a tick with dv=1, go to PRE if nibble==0x5, else DROP.
  - PRE: count 0x5 nibbles.
    - Nibble 0xD with count >= MIN_PREAMBLE_NIBBLES: go to DATA.
    - 0xD with count too low, any other nibble, or er=1: go to DROP.
    - dv=0: go to IDLE, no output.
  - DATA: assemble nibble pairs into bytes per NIBBLE_ORDER.
  - DROP: discard everything until dv=0 is sampled, then go to IDLE. No outputs, no counters.
- Byte holdback (DATA): each completed byte is held in a one-byte register.
  - When the next byte completes, the held byte is emitted (out_valid=1 for one clock on the cycle after that tick).
  - out_sof=1 on the first emitted byte of the frame.
- End of frame:
  - Triggered when dv=0 is sampled on a tick in DATA.
  - The held byte is emitted with out_eof=1, flags and frame_length, one clock after that tick. State returns to IDLE.
  - A 1-byte frame has out_sof and out_eof both set.
  - If DATA ends with zero bytes, nothing is emitted and the frame counts as bad.
- CRC: reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF), updated per byte including FCS. Good iff the final register equals 0xDEBB20E3.
- Error flags:
  - rx_er: any er=1 tick in DATA; the frame is still forwarded.
  - short: frame_length < MIN_FRAME_BYTES.
  - long: frame_length > MAX_FRAME_BYTES; bytes are still forwarded.
  - dribble: odd nibble count at EOF; the odd nibble is discarded.
- Counters: on EOF, frames_ok or frames_bad increments by 1 and wraps at 2^COUNTER_WIDTH.
- Reset released while dv=1: enter DROP, never parse a partial frame.
- Simultaneous events: a tick carrying both er=1 and dv=0 ends the frame; rx_er is set only if an er=1 was seen on an earlier tick in DATA.

Test Plan:
- Frame 0x55x7, 0x5D, then DA 11..66, SA AA..FF, 0x0800, 0x1234, FCS AB CD EF 01, sent high-nibble-first with NIBBLE_ORDER=1 -> 20 bytes out, first 0x11 with sof, last 0x01 with eof, frame_length=20, flags=5'b00101 (crc, short), frames_bad=1.
- 64-byte frame with correct FCS, NIBBLE_ORDER=0 -> 64 strobes, flags=0, frames_ok=1, out_data equals sent bytes in order.
- Same 64-byte frame with er=1 on byte 10 -> all 64 bytes out, flags[1]=1, frames_bad=1.
- dv drops after 129 DATA nibbles -> 64 bytes out, flags[4]=1.
- Preamble of 2 nibbles then 0xD (MIN=4) -> no out_valid for the whole frame, counters unchanged; the next good frame is received normally.
- reset asserted mid-DATA, released while dv=1 -> outputs 0 immediately, rest of frame dropped, next frame counted frames_ok=1.

Source files
------------

// File: rtl/mii_rx_frame_receiver.sv
// MII receive front end: oversamples the RX pins in the system clock domain, strips preamble/SFD,
// assembles bytes, streams them with SOF/EOF markers and reports CRC/length/error status per frame.
module mii_rx_frame_receiver #(
  parameter int SYNC_STAGES          = 2,
  parameter int NIBBLE_ORDER         = 0,
  parameter int MIN_PREAMBLE_NIBBLES = 4,
  parameter int MIN_FRAME_BYTES      = 64,
  parameter int MAX_FRAME_BYTES      = 1522,
  parameter int CRC_CHECK            = 1,
  parameter int COUNTER_WIDTH        = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mii_rx_clock,
  input  logic                     mii_rx_data_valid,
  input  logic                     mii_rx_error,
  input  logic [3:0]               mii_rx_data,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic [4:0]               out_error_flags,
  output logic [15:0]              frame_length,
  output logic [COUNTER_WIDTH-1:0] frames_ok,
  output logic [COUNTER_WIDTH-1:0] frames_bad,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam int          PC_W       = $clog2(MIN_PREAMBLE_NIBBLES + 1) + 1;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESID  = 32'hDEBB_20E3;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Bit layout of each synchroniser stage: {clk, dv, er, data[3:0]}
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] sync_d [SYNC_STAGES];
  logic       clk_prev_q, clk_prev_d;

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic              armed_q, armed_d;
  logic              half_q, half_d;
  logic [3:0]        nib_q, nib_d;
  logic [7:0]        held_q, held_d;
  logic              have_held_q, have_held_d;
  logic              first_q, first_d;
  logic              rx_er_q, rx_er_d;
  logic [15:0]       len_q, len_d;
  logic [31:0]       crc_q, crc_d;

  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_data_q, out_data_d;
  logic                     out_sof_q, out_sof_d;
  logic                     out_eof_q, out_eof_d;
  logic [4:0]               flags_q, flags_d;
  logic [15:0]              frame_length_q, frame_length_d;
  logic [COUNTER_WIDTH-1:0] frames_ok_q, frames_ok_d;
  logic [COUNTER_WIDTH-1:0] frames_bad_q, frames_bad_d;

  logic       tick, s_dv, s_er;
  logic [3:0] s_nib;
  logic [7:0] new_byte;
  logic [4:0] eof_flags;

  always_comb begin
    sync_d[0] = {mii_rx_clock, mii_rx_data_valid, mii_rx_error, mii_rx_data};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign clk_prev_d = sync_q[SYNC_STAGES-1][6];
  assign tick       = sync_q[SYNC_STAGES-1][6] & ~clk_prev_q;
  assign s_dv       = sync_q[SYNC_STAGES-1][5];
  assign s_er       = sync_q[SYNC_STAGES-1][4];
  assign s_nib      = sync_q[SYNC_STAGES-1][3:0];
  assign new_byte   = (NIBBLE_ORDER != 0) ? {nib_q, s_nib} : {s_nib, nib_q};

  assign eof_flags = {half_q,
                      int'(len_q) > MAX_FRAME_BYTES,
                      int'(len_q) < MIN_FRAME_BYTES,
                      rx_er_q,
                      (CRC_CHECK != 0) && (crc_q != CRC_RESID)};

  // out_valid is a one-cycle strobe with no back-pressure: out_data/out_sof/out_eof are meaningful
  // only while it is high; out_error_flags/frame_length only while out_valid && out_eof.
  always_comb begin
    state_d        = state_q;
    pre_cnt_d      = pre_cnt_q;
    armed_d        = armed_q;
    half_d         = half_q;
    nib_d          = nib_q;
    held_d         = held_q;
    have_held_d    = have_held_q;
    first_d        = first_q;
    rx_er_d        = rx_er_q;
    len_d          = len_q;
    crc_d          = crc_q;
    out_valid_d    = 1'b0;
    out_data_d     = 8'd0;
    out_sof_d      = 1'b0;
    out_eof_d      = 1'b0;
    flags_d        = 5'd0;
    frame_length_d = 16'd0;
    frames_ok_d    = frames_ok_q;
    frames_bad_d   = frames_bad_q;

    if (tick) begin
      // A frame may only start after dv=0 has been seen, so a reset inside a frame never parses its tail.
      if (!s_dv) armed_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (s_dv) begin
            if (armed_q && s_nib == 4'h5) begin
              state_d   = S_PRE;
              pre_cnt_d = PC_W'(1);
            end else begin
              state_d = S_DROP;
            end
          end
        end
        S_PRE: begin
          if (!s_dv) begin
            state_d = S_IDLE;
          end else if (s_er) begin
            state_d = S_DROP;
          end else if (s_nib == 4'h5) begin
            if (pre_cnt_q < PC_W'(MIN_PREAMBLE_NIBBLES)) pre_cnt_d = pre_cnt_q + PC_W'(1);
          end else if (s_nib == 4'hD && pre_cnt_q >= PC_W'(MIN_PREAMBLE_NIBBLES)) begin
            state_d     = S_DATA;
            half_d      = 1'b0;
            have_held_d = 1'b0;
            first_d     = 1'b1;
            rx_er_d     = 1'b0;
            len_d       = 16'd0;
            crc_d       = CRC_INIT;
          end else begin
            state_d = S_DROP;
          end
        end
        S_DATA: begin
          if (!s_dv) begin
            state_d = S_IDLE;
            if (have_held_q) begin
              out_valid_d    = 1'b1;
              out_data_d     = held_q;
              out_sof_d      = first_q;
              out_eof_d      = 1'b1;
              flags_d        = eof_flags;
              frame_length_d = len_q;
            end
            if (have_held_q && eof_flags == 5'd0) frames_ok_d = frames_ok_q + COUNTER_WIDTH'(1);
            else frames_bad_d = frames_bad_q + COUNTER_WIDTH'(1);
          end else begin
            if (s_er) rx_er_d = 1'b1;
            if (!half_q) begin
              nib_d  = s_nib;
              half_d = 1'b1;
            end else begin
              half_d      = 1'b0;
              crc_d       = crc_byte(crc_q, new_byte);
              if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
              held_d      = new_byte;
              have_held_d = 1'b1;
              if (have_held_q) begin
                out_valid_d = 1'b1;
                out_data_d  = held_q;
                out_sof_d   = first_q;
                first_d     = 1'b0;
              end
            end
          end
        end
        default: begin
          if (!s_dv) state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 7'd0;
      clk_prev_q     <= 1'b0;
      state_q        <= S_IDLE;
      pre_cnt_q      <= '0;
      armed_q        <= 1'b0;
      half_q         <= 1'b0;
      nib_q          <= 4'd0;
      held_q         <= 8'd0;
      have_held_q    <= 1'b0;
      first_q        <= 1'b0;
      rx_er_q        <= 1'b0;
      len_q          <= 16'd0;
      crc_q          <= CRC_INIT;
      out_valid_q    <= 1'b0;
      out_data_q     <= 8'd0;
      out_sof_q      <= 1'b0;
      out_eof_q      <= 1'b0;
      flags_q        <= 5'd0;
      frame_length_q <= 16'd0;
      frames_ok_q    <= '0;
      frames_bad_q   <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      clk_prev_q     <= clk_prev_d;
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      armed_q        <= armed_d;
      half_q         <= half_d;
      nib_q          <= nib_d;
      held_q         <= held_d;
      have_held_q    <= have_held_d;
      first_q        <= first_d;
      rx_er_q        <= rx_er_d;
      len_q          <= len_d;
      crc_q          <= crc_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_sof_q      <= out_sof_d;
      out_eof_q      <= out_eof_d;
      flags_q        <= flags_d;
      frame_length_q <= frame_length_d;
      frames_ok_q    <= frames_ok_d;
      frames_bad_q   <= frames_bad_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_sof         = out_sof_q;
  assign out_eof         = out_eof_q;
  assign out_error_flags = flags_q;
  assign frame_length    = frame_length_q;
  assign frames_ok       = frames_ok_q;
  assign frames_bad      = frames_bad_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mii_rx_frame_receiver.sv
// Bench for mii_rx_frame_receiver: two instances (low- and high-nibble-first) share one MII stream;
// each output stream is scored against a frame-level reference model.
module tb_mii_rx_frame_receiver;

  localparam logic [31:0] POLY  = 32'hEDB8_8320;
  localparam logic [31:0] RESID = 32'hDEBB_20E3;

  // clock / reset
  logic clk = 1'b0;
  logic mii_clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  always #40 mii_clk = ~mii_clk;

  logic       dv, er;
  logic [3:0] rxd;

  logic        ov   [2];
  logic [7:0]  od   [2];
  logic        osof [2];
  logic        oeof [2];
  logic [4:0]  oflg [2];
  logic [15:0] olen [2];
  logic [15:0] fok  [2];
  logic [15:0] fbad [2];
  logic [1:0]  dbg  [2];

  mii_rx_frame_receiver #(.NIBBLE_ORDER(0)) u_dut0 (
    .clock(clk), .reset(rst_n), .mii_rx_clock(mii_clk), .mii_rx_data_valid(dv),
    .mii_rx_error(er), .mii_rx_data(rxd), .out_valid(ov[0]), .out_data(od[0]),
    .out_sof(osof[0]), .out_eof(oeof[0]), .out_error_flags(oflg[0]), .frame_length(olen[0]),
    .frames_ok(fok[0]), .frames_bad(fbad[0]), .dbg_state(dbg[0]));

  mii_rx_frame_receiver #(.NIBBLE_ORDER(1)) u_dut1 (
    .clock(clk), .reset(rst_n), .mii_rx_clock(mii_clk), .mii_rx_data_valid(dv),
    .mii_rx_error(er), .mii_rx_data(rxd), .out_valid(ov[1]), .out_data(od[1]),
    .out_sof(osof[1]), .out_eof(oeof[1]), .out_error_flags(oflg[1]), .frame_length(olen[1]),
    .frames_ok(fok[1]), .frames_bad(fbad[1]), .dbg_state(dbg[1]));

  // Captured output beats: {sof, eof, flags[4:0], len[15:0], data[7:0]}
  logic [30:0] rx0_q[$];
  logic [30:0] rx1_q[$];
  always @(negedge clk) begin
    if (ov[0]) rx0_q.push_back({osof[0], oeof[0], oflg[0], olen[0], od[0]});
    if (ov[1]) rx1_q.push_back({osof[1], oeof[1], oflg[1], olen[1], od[1]});
  end

  // scoreboard state
  logic [7:0]  exp_q[$];
  logic [7:0]  fr_bytes[$];
  logic [3:0]  fr_nib[$];
  bit          fr_er[$];
  logic [3:0]  save_nib[$];
  int          exp_ok[2];
  int          exp_bad[2];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ POLY;
      else r = r >> 1;
    end
    return r;
  endfunction

  // driver tasks
  task automatic drive_nib(input logic v, input logic e, input logic [3:0] d);
    @(negedge mii_clk);
    dv = v; er = e; rxd = d;
  endtask

  task automatic make_random(input int n);
    fr_bytes.delete();
    for (int i = 0; i < n; i++) fr_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (fr_bytes[i]) c = crc_upd(c, fr_bytes[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr_bytes.push_back(c[8*i +: 8]);
  endtask

  task automatic bytes_to_nibs(input bit hi_first);
    fr_nib.delete();
    fr_er.delete();
    foreach (fr_bytes[i]) begin
      fr_nib.push_back(hi_first ? fr_bytes[i][7:4] : fr_bytes[i][3:0]);
      fr_nib.push_back(hi_first ? fr_bytes[i][3:0] : fr_bytes[i][7:4]);
      fr_er.push_back(1'b0);
      fr_er.push_back(1'b0);
    end
  endtask

  task automatic send_frame(input int pre_n);
    rx0_q.delete();
    rx1_q.delete();
    for (int i = 0; i < pre_n; i++) drive_nib(1'b1, 1'b0, 4'h5);
    drive_nib(1'b1, 1'b0, 4'hD);
    foreach (fr_nib[i]) drive_nib(1'b1, fr_er[i], fr_nib[i]);
    for (int i = 0; i < 6; i++) drive_nib(1'b0, 1'b0, 4'h0);
  endtask

  // Reference model: frame bytes are the nibble pairs in the instance's order, flags from whole-frame rules.
  task automatic check_frame(input int k, input string name);
    logic [30:0] got[$];
    logic [7:0]  b;
    logic [31:0] c;
    logic [4:0]  flg;
    int          n, nb;
    bit          anyer;
    if (k == 0) got = rx0_q; else got = rx1_q;
    n = fr_nib.size();
    nb = n / 2;
    anyer = 0;
    foreach (fr_er[i]) if (fr_er[i]) anyer = 1;
    exp_q.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < nb; i++) begin
      b = (k == 1) ? {fr_nib[2*i], fr_nib[2*i+1]} : {fr_nib[2*i+1], fr_nib[2*i]};
      exp_q.push_back(b);
      c = crc_upd(c, b);
    end
    flg = {(n % 2) == 1, nb > 1522, nb < 64, anyer, c != RESID};
    if (nb == 0 || flg != 5'd0) exp_bad[k]++; else exp_ok[k]++;
    check($sformatf("%s.u%0d.count", name, k), got.size(), nb);
    for (int i = 0; i < nb && i < got.size(); i++) begin
      check($sformatf("%s.u%0d.beat%0d", name, k, i), {got[i][30:29], got[i][7:0]},
            {i == 0, i == nb - 1, exp_q[i]});
      if (i == nb - 1) begin
        check($sformatf("%s.u%0d.flags", name, k), got[i][28:24], flg);
        check($sformatf("%s.u%0d.len", name, k), got[i][23:8], nb);
      end
    end
    check($sformatf("%s.u%0d.ok", name, k), fok[k], exp_ok[k]);
    check($sformatf("%s.u%0d.bad", name, k), fbad[k], exp_bad[k]);
  endtask

  task automatic check_both(input string name);
    check_frame(0, name);
    check_frame(1, name);
  endtask

  task automatic check_none(input string name);
    check({name, ".u0.count"}, rx0_q.size(), 0);
    check({name, ".u1.count"}, rx1_q.size(), 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.u%0d.ok", name, k), fok[k], exp_ok[k]);
      check($sformatf("%s.u%0d.bad", name, k), fbad[k], exp_bad[k]);
    end
  endtask

  initial begin
    rst_n = 1'b0; dv = 1'b0; er = 1'b0; rxd = 4'h0;
    exp_ok = '{0, 0};
    exp_bad = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid", ov[0], 0);
    check("reset.data", od[0], 0);
    check("reset.sof_eof", {osof[0], oeof[0]}, 0);
    check("reset.flags", oflg[0], 0);
    check("reset.len", olen[0], 0);
    check("reset.counters", {fok[0], fbad[0]}, 0);
    check("reset.state", dbg[0], 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive_nib(1'b0, 1'b0, 4'h0);

    // Directed frame sent high-nibble-first after a 15-nibble preamble.
    fr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                 8'hEE, 8'hFF, 8'h08, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    bytes_to_nibs(1'b1);
    send_frame(15);
    check_both("hi_first");
    if (rx1_q.size() == 20) begin
      check("hi_first.first", {rx1_q[0][30], rx1_q[0][7:0]}, {1'b1, 8'h11});
      check("hi_first.last", {rx1_q[19][29], rx1_q[19][7:0]}, {1'b1, 8'h01});
      check("hi_first.flags", rx1_q[19][28:24], 5'b00101);
      check("hi_first.len", rx1_q[19][23:8], 20);
    end
    check("hi_first.bad", fbad[1], 1);

    // 64-byte frame with good FCS, low nibble first.
    make_random(60);
    add_fcs();
    bytes_to_nibs(1'b0);
    save_nib = fr_nib;
    send_frame(7);
    check_both("good64");
    check("good64.ok", fok[0], 1);

    fr_er[20] = 1'b1;
    send_frame(7);
    check_both("rxer64");

    fr_er[20] = 1'b0;
    fr_nib.push_back(4'hA);
    fr_er.push_back(1'b0);
    send_frame(7);
    check_both("dribble");

    // Preamble too short: whole frame dropped, counters still.
    fr_nib = save_nib;
    fr_er.delete();
    foreach (fr_nib[i]) fr_er.push_back(1'b0);
    send_frame(2);
    check_none("pre2");
    send_frame(3);
    check_none("pre3");
    send_frame(4);
    check_both("pre4");

    make_random(1);
    bytes_to_nibs(1'b0);
    send_frame(7);
    check_both("one_byte");

    fr_nib.delete();
    fr_er.delete();
    send_frame(7);
    check_both("zero_byte");

    make_random(59);
    add_fcs();
    bytes_to_nibs(1'b0);
    send_frame(7);
    check_both("short63");

    make_random(1519);
    add_fcs();
    bytes_to_nibs(1'b0);
    send_frame(7);
    check_both("long1523");

    // Reset in the middle of a frame, released while dv is still high.
    make_random(60);
    add_fcs();
    bytes_to_nibs(1'b0);
    rx0_q.delete();
    rx1_q.delete();
    for (int i = 0; i < 7; i++) drive_nib(1'b1, 1'b0, 4'h5);
    drive_nib(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 40; i++) drive_nib(1'b1, 1'b0, fr_nib[i]);
    #3 rst_n = 1'b0;
    #1;
    check("midrst.valid", ov[0], 0);
    check("midrst.counters", {fok[0], fbad[0]}, 0);
    check("midrst.state", dbg[0], 0);
    for (int i = 40; i < 50; i++) drive_nib(1'b1, 1'b0, fr_nib[i]);
    #3 rst_n = 1'b1;
    exp_ok = '{0, 0};
    exp_bad = '{0, 0};
    rx0_q.delete();
    rx1_q.delete();
    for (int i = 0; i < 5; i++) drive_nib(1'b1, 1'b0, 4'h5);
    drive_nib(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 40; i++) drive_nib(1'b1, 1'b0, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 6; i++) drive_nib(1'b0, 1'b0, 4'h0);
    check_none("midrst.tail");
    send_frame(7);
    check_both("after_rst");
    check("after_rst.ok", fok[0], 1);

    // Randomised frames: length, FCS, order, RX_ER and dribble all drawn at random.
    for (int f = 0; f < 6; f++) begin
      make_random($urandom_range(1, 90));
      if ($urandom_range(0, 1) == 1) add_fcs();
      bytes_to_nibs(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) fr_er[$urandom_range(0, fr_nib.size() - 1)] = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        fr_nib.push_back(4'($urandom_range(0, 15)));
        fr_er.push_back(1'b0);
      end
      send_frame($urandom_range(4, 12));
      check_both($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
